// File: rtl/fifo_chk_pkg.sv
// Shared types for the FIFO protocol checker.
// Error codes and the mismatch priority encoder.
package fifo_chk_pkg;

  typedef enum logic [3:0] {
    ERR_NONE      = 4'd0,
    ERR_DATA      = 4'd1,
    ERR_WR_ACK    = 4'd2,
    ERR_OVERFLOW  = 4'd3,
    ERR_UNDERFLOW = 4'd4,
    ERR_FULL      = 4'd5,
    ERR_EMPTY     = 4'd6,
    ERR_AFULL     = 4'd7,
    ERR_AEMPTY    = 4'd8
  } err_code_e;

  localparam logic [3:0] CODE_NONE      = 4'd0;
  localparam logic [3:0] CODE_DATA      = 4'd1;
  localparam logic [3:0] CODE_WR_ACK    = 4'd2;
  localparam logic [3:0] CODE_OVERFLOW  = 4'd3;
  localparam logic [3:0] CODE_UNDERFLOW = 4'd4;
  localparam logic [3:0] CODE_FULL      = 4'd5;
  localparam logic [3:0] CODE_EMPTY     = 4'd6;
  localparam logic [3:0] CODE_AFULL     = 4'd7;
  localparam logic [3:0] CODE_AEMPTY    = 4'd8;

  localparam int MISM_W = 8;

  // Bit i of the vector maps to code i+1; the lowest set bit wins.
  function automatic err_code_e chk_prio(
    input logic [MISM_W-1:0] mismatch_vec
  );
    err_code_e code;
    code = ERR_NONE;
    for (int i = MISM_W - 1; i >= 0; i--) begin
      if (mismatch_vec[i]) begin
        code = err_code_e'(4'(i + 1));
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/fifo_ref_model.sv
// Shadow model of the observed FIFO: memory, pointers,
// occupancy and the expected registered handshakes.
module fifo_ref_model
  import fifo_chk_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [FIFO_WIDTH-1:0]         data_in,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          exp_wr_ack,
  output logic                          exp_overflow,
  output logic                          exp_underflow,
  output logic [FIFO_WIDTH-1:0]         exp_data,
  output logic                          data_seen,
  output logic                          cmp_v
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  run;

  assign run   = rst_n && !rst;
  assign wr_ok = wr_en && (count != DEPTH_C);
  assign rd_ok = rd_en && (count != '0);

  always_ff @(posedge clk) begin
    if (run && wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      exp_wr_ack    <= 1'b0;
      exp_overflow  <= 1'b0;
      exp_underflow <= 1'b0;
      exp_data      <= '0;
      data_seen     <= 1'b0;
      cmp_v         <= 1'b0;
    end else begin
      cmp_v         <= 1'b1;
      exp_wr_ack    <= wr_ok;
      exp_overflow  <= wr_en && !wr_ok;
      exp_underflow <= rd_en && (count == '0);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      // exp_data only moves on an accepted read
      if (rd_ok) begin
        exp_data  <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
        data_seen <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_protocol_checker.sv
// In-line FIFO protocol checker: compares the DUT against a
// shadow model and keeps pass/fail counters and error latches.
module fifo_protocol_checker
  import fifo_chk_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16,
  parameter int DATA_CHECK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  almostfull,
  input  logic                  almostempty,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  test_finished,
  output logic [CNT_W-1:0]      correct_count,
  output logic [CNT_W-1:0]      error_count,
  output logic                  err_pulse,
  output logic                  err_sticky,
  output logic [3:0]            first_err_code,
  output logic                  report_valid
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [CW-1:0]         count;
  logic                  exp_wr_ack;
  logic                  exp_overflow;
  logic                  exp_underflow;
  logic [FIFO_WIDTH-1:0] exp_data;
  logic                  data_seen;
  logic                  cmp_v;

  logic [MISM_W-1:0]     mism;
  err_code_e             code;
  logic                  any_err;
  logic                  cmp_ok;

  fifo_ref_model #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_model (
    .clk           (clk),
    .rst           (rst),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .data_in       (data_in),
    .count         (count),
    .exp_wr_ack    (exp_wr_ack),
    .exp_overflow  (exp_overflow),
    .exp_underflow (exp_underflow),
    .exp_data      (exp_data),
    .data_seen     (data_seen),
    .cmp_v         (cmp_v)
  );

  always_comb begin
    mism    = '0;
    mism[0] = (DATA_CHECK != 0) && data_seen
              && (data_out != exp_data);
    mism[1] = wr_ack != exp_wr_ack;
    mism[2] = overflow != exp_overflow;
    mism[3] = underflow != exp_underflow;
    mism[4] = full != (count == DEPTH_C);
    mism[5] = empty != (count == '0);
    mism[6] = almostfull != (count == DEPTH_C - 1'b1);
    mism[7] = almostempty != (count == CW'(1));
  end

  assign code    = chk_prio(mism);
  assign any_err = |mism;
  // a cycle where rst_n is low discards the pending compare
  assign cmp_ok  = cmp_v && rst_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      correct_count  <= '0;
      error_count    <= '0;
      err_pulse      <= 1'b0;
      err_sticky     <= 1'b0;
      first_err_code <= '0;
      report_valid   <= 1'b0;
    end else begin
      err_pulse <= cmp_ok && any_err;
      if (test_finished) begin
        report_valid <= 1'b1;
      end
      if (cmp_ok && !report_valid) begin
        if (any_err) begin
          if (error_count != '1) begin
            error_count <= error_count + 1'b1;
          end
          if (!err_sticky) begin
            err_sticky     <= 1'b1;
            first_err_code <= code;
          end
        end else if (correct_count != '1) begin
          correct_count <= correct_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_protocol_checker.sv
// Bench for fifo_protocol_checker: drives a stand-in FIFO with
// optional output corruption and scores the checker each cycle.
module tb_fifo_protocol_checker;

  typedef struct {
    logic        w;
    logic        r;
    logic [15:0] d;
    logic [7:0]  m;
    logic [3:0]  c;
  } vec_t;

  typedef struct {
    logic       valid;
    logic [3:0] code;
  } sb_rec_t;

  typedef struct {
    logic [7:0] m;
    logic [3:0] c;
  } prio_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rst_n;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] data_in;
  logic        test_finished;
  logic [7:0]  inj;

  // stand-in FIFO (correct unless inj flips an output)
  logic [15:0] smem [8];
  logic [2:0]  swp;
  logic [2:0]  srp;
  logic [3:0]  socc;
  logic        s_ack;
  logic        s_ov;
  logic        s_un;
  logic [15:0] s_dq;
  logic        s_wa;
  logic        s_ra;

  assign s_wa = wr_en && (socc < 4'd8);
  assign s_ra = rd_en && (socc > 4'd0);

  always @(posedge clk) begin
    if (!rst_n) begin
      swp   <= '0;
      srp   <= '0;
      socc  <= '0;
      s_ack <= 1'b0;
      s_ov  <= 1'b0;
      s_un  <= 1'b0;
      s_dq  <= '0;
    end else begin
      if (s_wa) begin
        smem[swp] <= data_in;
        swp <= swp + 3'd1;
      end
      if (s_ra) begin
        s_dq <= smem[srp];
        srp  <= srp + 3'd1;
      end
      socc  <= socc + 4'(s_wa) - 4'(s_ra);
      s_ack <= s_wa;
      s_ov  <= wr_en && !s_wa;
      s_un  <= rd_en && (socc == 4'd0);
    end
  end

  logic [15:0] data_out;
  logic        full, empty, afull, aempty;
  logic        wr_ack, overflow, underflow;

  assign data_out  = s_dq ^ (inj[0] ? 16'h00FF : 16'h0000);
  assign wr_ack    = s_ack ^ inj[1];
  assign overflow  = s_ov ^ inj[2];
  assign underflow = s_un ^ inj[3];
  assign full      = (socc == 4'd8) ^ inj[4];
  assign empty     = (socc == 4'd0) ^ inj[5];
  assign afull     = (socc == 4'd7) ^ inj[6];
  assign aempty    = (socc == 4'd1) ^ inj[7];

  logic [15:0] a_corr, a_err;
  logic        a_pulse, a_sticky, a_rep;
  logic [3:0]  a_code;
  logic [3:0]  b_corr, b_err;
  logic        b_pulse, b_sticky, b_rep;
  logic [3:0]  b_code;

  fifo_protocol_checker #(
    .FIFO_WIDTH (16),
    .FIFO_DEPTH (8),
    .CNT_W      (16),
    .DATA_CHECK (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .data_in        (data_in),
    .data_out       (data_out),
    .full           (full),
    .empty          (empty),
    .almostfull     (afull),
    .almostempty    (aempty),
    .wr_ack         (wr_ack),
    .overflow       (overflow),
    .underflow      (underflow),
    .test_finished  (test_finished),
    .correct_count  (a_corr),
    .error_count    (a_err),
    .err_pulse      (a_pulse),
    .err_sticky     (a_sticky),
    .first_err_code (a_code),
    .report_valid   (a_rep)
  );

  fifo_protocol_checker #(
    .FIFO_WIDTH (16),
    .FIFO_DEPTH (8),
    .CNT_W      (4),
    .DATA_CHECK (1)
  ) dut_sat (
    .clk            (clk),
    .rst            (rst),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .data_in        (data_in),
    .data_out       (data_out),
    .full           (full),
    .empty          (empty),
    .almostfull     (afull),
    .almostempty    (aempty),
    .wr_ack         (wr_ack),
    .overflow       (overflow),
    .underflow      (underflow),
    .test_finished  (test_finished),
    .correct_count  (b_corr),
    .error_count    (b_err),
    .err_pulse      (b_pulse),
    .err_sticky     (b_sticky),
    .first_err_code (b_code),
    .report_valid   (b_rep)
  );

  int checks   = 0;
  int failures = 0;

  sb_rec_t sbq[$];
  logic        cmpv_m;
  int          e_corr, e_err;
  logic        e_pulse, e_sticky, e_rep;
  logic [3:0]  e_code;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, queue the expected verdict for the
  // compare resolved at this edge, then score the checker.
  task automatic step(input logic w, input logic r,
                      input logic [15:0] d, input logic [7:0] m,
                      input logic [3:0] c);
    sb_rec_t rec;
    logic    frz;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    inj     = m;
    rec.valid = cmpv_m && rst_n && !rst;
    rec.code  = c;
    sbq.push_back(rec);
    @(posedge clk);
    #1;
    rec = sbq.pop_front();
    if (rst) begin
      cmpv_m = 1'b0; e_corr = 0; e_err = 0;
      e_pulse = 1'b0; e_sticky = 1'b0;
      e_code = 4'd0; e_rep = 1'b0;
    end else begin
      frz     = e_rep;
      cmpv_m  = rst_n;
      e_pulse = rec.valid && (rec.code != 4'd0);
      if (test_finished) e_rep = 1'b1;
      if (rec.valid && !frz) begin
        if (rec.code != 4'd0) begin
          e_err++;
          if (!e_sticky) begin
            e_sticky = 1'b1;
            e_code   = rec.code;
          end
        end else begin
          e_corr++;
        end
      end
    end
    chk("err_pulse", 32'(a_pulse), 32'(e_pulse));
    chk("correct_count", 32'(a_corr), 32'(e_corr));
    chk("error_count", 32'(a_err), 32'(e_err));
    chk("err_sticky", 32'(a_sticky), 32'(e_sticky));
    chk("first_err_code", 32'(a_code), 32'(e_code));
    chk("report_valid", 32'(a_rep), 32'(e_rep));
  endtask

  function automatic vec_t v(input logic w, input logic r,
                             input logic [15:0] d,
                             input logic [7:0] m,
                             input logic [3:0] c);
    vec_t t;
    t.w = w; t.r = r; t.d = d; t.m = m; t.c = c;
    return t;
  endfunction

  vec_t  tbl[$];
  prio_t ptbl[$];

  initial begin
    // fill: data corruption before any read is masked
    for (int i = 1; i <= 9; i++)
      tbl.push_back(v(1, 0, 16'(i), (i == 3) ? 8'h01 : 8'h00, 0));
    // drain past empty
    for (int i = 0; i < 9; i++)
      tbl.push_back(v(0, 1, 16'h0, 8'h00, 0));
    // rd+wr at empty, refill, rd+wr at full
    tbl.push_back(v(1, 1, 16'hA5A5, 8'h00, 0));
    for (int i = 1; i <= 7; i++)
      tbl.push_back(v(1, 0, 16'h0010 + 16'(i), 8'h00, 0));
    tbl.push_back(v(1, 1, 16'hBEEF, 8'h00, 0));
    tbl.push_back(v(0, 0, 16'h0, 8'h00, 0));
    // injected faults: bad data after the 3rd read, then bad wr_ack
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(0, 1, 16'h0, 8'h00, 0));
    tbl.push_back(v(0, 0, 16'h0, 8'h01, 1));
    tbl.push_back(v(1, 0, 16'h0055, 8'h00, 0));
    tbl.push_back(v(0, 0, 16'h0, 8'h02, 2));
    tbl.push_back(v(0, 0, 16'h0, 8'h00, 0));

    ptbl.push_back('{8'h01, 4'd1});
    ptbl.push_back('{8'hFF, 4'd1});
    ptbl.push_back('{8'hFE, 4'd2});
    ptbl.push_back('{8'h04, 4'd3});
    ptbl.push_back('{8'h08, 4'd4});
    ptbl.push_back('{8'h10, 4'd5});
    ptbl.push_back('{8'h20, 4'd6});
    ptbl.push_back('{8'h40, 4'd7});
    ptbl.push_back('{8'h80, 4'd8});
    ptbl.push_back('{8'hA0, 4'd6});

    rst = 1'b1; rst_n = 1'b0; test_finished = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; data_in = '0; inj = '0;
    cmpv_m = 1'b0; e_corr = 0; e_err = 0; e_pulse = 1'b0;
    e_sticky = 1'b0; e_code = '0; e_rep = 1'b0;

    // reset sequence
    repeat (2) step(0, 0, 0, 0, 0);
    chk("sat_reset_corr", 32'(b_corr), 0);
    chk("sat_reset_rep", 32'(b_rep), 0);
    rst = 1'b0;
    repeat (3) step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (11) step(0, 0, 0, 0, 0);
    chk("idle_correct", 32'(a_corr), 10);
    chk("idle_error", 32'(a_err), 0);

    foreach (tbl[i]) step(tbl[i].w, tbl[i].r, tbl[i].d,
                          tbl[i].m, tbl[i].c);
    chk("fault_error_count", 32'(a_err), 2);
    chk("fault_first_code", 32'(a_code), 1);

    // rst_n drop mid-burst: the pending compare is discarded
    step(0, 1, 0, 0, 0);
    rst_n = 1'b0;
    step(0, 0, 0, 8'h01, 1);
    step(0, 0, 0, 8'h00, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h01, 0);
    step(1, 0, 16'h0005, 8'h00, 0);
    chk("rstn_drop_errors", 32'(a_err), 2);

    // error-code priority
    foreach (ptbl[i]) begin
      rst = 1'b1; rst_n = 1'b0;
      step(0, 0, 0, 0, 0);
      rst = 1'b0;
      step(0, 0, 0, 0, 0);
      rst_n = 1'b1;
      step(1, 0, 16'h0077, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, ptbl[i].m, ptbl[i].c);
      chk("prio_code", 32'(a_code), 32'(ptbl[i].c));
    end

    // saturation and report freeze
    rst = 1'b1; rst_n = 1'b0;
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    repeat (20) step(0, 0, 0, 0, 0);
    chk("sat_correct", 32'(b_corr), 15);
    chk("sat_error", 32'(b_err), 0);
    chk("wide_correct", 32'(a_corr), 20);
    test_finished = 1'b1;
    step(0, 0, 0, 0, 0);
    test_finished = 1'b0;
    repeat (2) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 8'h20, 6);
    step(0, 0, 0, 0, 0);
    chk("frozen_sat_corr", 32'(b_corr), 15);
    chk("frozen_sat_err", 32'(b_err), 0);
    chk("frozen_sat_rep", 32'(b_rep), 1);
    chk("frozen_corr", 32'(a_corr), 21);
    chk("frozen_code", 32'(a_code), 0);
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("rst_clears_report", 32'(b_rep), 0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_protocol_checker.md
# fifo_protocol_checker

Synthesizable, parametrised in-line checker for the team's synchronous FIFO. It observes every DUT port and keeps a shadow reference model: stored data, occupancy, and expected flag and handshake outputs. Each cycle it compares the DUT against the model and keeps saturating pass/fail counters plus a sticky first-error record. It replaces the class-based monitor/scoreboard pair on emulation and FPGA builds, and is bound beside the FIFO in both simulation and hardware.

## Interface
- FIFO_WIDTH, 16, data width of the observed FIFO
- FIFO_DEPTH, 8, FIFO entries; power of two, ≥ 4
- CNT_W, 16, width of the pass/fail counters
- DATA_CHECK, 1, 1 = compare data_out; 0 = flags and handshakes only
- clk  in  1  checker and DUT clock
- rst  in  1  checker reset; synchronous, active-high
- rst_n  in  1  observed DUT reset (active-low)
- wr_en, rd_en  in  1  observed DUT inputs
- data_in  in  FIFO_WIDTH  observed DUT write data
- data_out  in  FIFO_WIDTH  observed DUT read data
- full, empty, almostfull, almostempty  in  1  observed combinational flags
- wr_ack, overflow, underflow  in  1  observed registered handshakes
- test_finished  in  1  end-of-test request
- correct_count  out  CNT_W  cycles compared with no mismatch
- error_count  out  CNT_W  cycles with at least one mismatch
- err_pulse  out  1  high in any cycle with a mismatch
- err_sticky  out  1  set on the first mismatch; cleared only by rst
- first_err_code  out  4  code of the first mismatch
- report_valid  out  1  latched when test_finished is sampled high

## Operation
Model state:
- count, width $clog2(FIFO_DEPTH)+1.
- wr_ptr and rd_ptr, width $clog2(FIFO_DEPTH); both wrap naturally.
- Shadow memory of FIFO_DEPTH × FIFO_WIDTH.

Model update on a cycle with rst_n = 1:
- Write accepted when wr_en && count != DEPTH.
- Read accepted when rd_en && count != 0.
- wr_en && rd_en with count = 0: write only.
- wr_en && rd_en with count = DEPTH: read only.
- Otherwise both operations proceed and count is unchanged.

Expected registered outputs, computed from the cycle's inputs:
- exp_wr_ack = write accepted.
- exp_overflow = wr_en && !write accepted.
- exp_underflow = rd_en && count == 0.
- exp_data = mem[rd_ptr] on an accepted read; otherwise holds its previous value.

Expected combinational flags, derived from the updated count:
- full: count == DEPTH.
- empty: count == 0.
- almostfull: count == DEPTH-1.
- almostempty: count == 1.

Error codes, reported in priority order (lowest non-zero code wins):
- 1 data, 2 wr_ack, 3 overflow, 4 underflow, 5 full, 6 empty, 7 almostfull, 8 almostempty.
- 0 means no error.

DUT reset handling:
- While rst_n = 0, the model clears (count, pointers, exp_* all 0).
- The compare-valid flag (cmp_v) clears, and no counting occurs.
- cmp_v is set one cycle after rst_n returns high.
- Data compare is masked until the first accepted read has propagated.

Counting:
- Each compare-valid cycle increments exactly one counter: error_count if any code is non-zero, otherwise correct_count.
- Both counters saturate at all-ones.

test_finished:
- Sets report_valid, which freezes both counters and first_err_code.
- report_valid clears only on rst.

## Timing
- Reset values, all outputs 0: correct_count, error_count, err_pulse, err_sticky, first_err_code, report_valid. The model is also cleared.
- Cycle N edge: capture inputs, update the model, register exp_*.
- Cycle N+1: compare the DUT's registered outputs against exp_*, and the DUT's flags against the updated model count. Counters and err_pulse update at the N+1 edge, giving 1-cycle comparison latency and 2 cycles from stimulus to counter.
- err_sticky and first_err_code load only when err_sticky = 0.
- rst asserted mid-test clears everything at the next edge, including the report latch.
- A rst_n drop mid-burst discards the in-flight comparison; no count is made for it.

## Structure
- fifo_chk_pkg holds:
  - the err_code_e enum (4-bit);
  - the CODE_* localparams;
  - the function chk_prio(mismatch_vec) → err_code_e.
- Sub-module fifo_ref_model holds the shadow memory, pointers, count and exp_* registers.
- The top level holds the comparators, counters and first-error/report latches.

## Test plan
All scenarios use FIFO_DEPTH = 8, FIFO_WIDTH = 16 and a correct DUT unless stated.
- Reset sequence: rst=1 for 2 cycles, rst_n low for 3 cycles, then idle 10 cycles → correct_count = 10, error_count = 0, err_sticky = 0.
- Fill and overflow: write 0x0001..0x0009 on 9 consecutive cycles →
  - full expected after the 8th write; almostfull after the 7th;
  - overflow expected 1 on the 9th;
  - correct_count = 9, error_count = 0.
- Drain and underflow: read 9 times → data_out 0x0001..0x0008 in order, underflow on the 9th, empty = 1, no errors.
- Simultaneous rd/wr edge cases: rd_en && wr_en at count 0, then at count 8 → write only (count becomes 1), then read only (count becomes 7); no errors.
- Injected fault: force DUT data_out wrong on the 3rd read →
  - err_pulse high for 1 cycle;
  - first_err_code = 1, err_sticky = 1, error_count = 1.
  - A later forced wr_ack error increments error_count to 2 with first_err_code still 1.
- Report freeze and saturation: with CNT_W = 4, run 20 clean cycles → correct_count = 15. Assert test_finished; further cycles leave both counters frozen with report_valid = 1.
